// File: rtl/hap_pkg.sv
// Shared definitions for the Harvard architecture processor.
// This package holds the default datapath widths, the fetch FSM state codes, and the
// branch/jump mode codes that the fetch stage shares with the compare-and-branch unit.
package hap_pkg;

  // Default instruction address / PC width and instruction word width
  localparam int HAP_ADDR_W  = 8;
  localparam int HAP_INSTR_W = 16;

  // Fetch FSM state encoding (plain constants so legacy tools can consume them)
  localparam logic [1:0] FS_IDLE   = 2'd0;
  localparam logic [1:0] FS_WAIT   = 2'd1;
  localparam logic [1:0] FS_HOLD   = 2'd2;
  localparam logic [1:0] FS_SQUASH = 2'd3;

  // Branch/jump modes decoded by the compare-and-branch unit
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_JMP  = 3'd5,
    BR_JAL  = 3'd6
  } br_mode_t;

  // True in the states that keep a read outstanding at the instruction memory
  function automatic logic fetch_busy(input logic [1:0] st);
    return (st == FS_WAIT) || (st == FS_SQUASH);
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch stage.
// The block holds the PC and issues one read to the instruction memory at a time.
// It hands each fetched word, together with its PC, to decode through a valid/ready pair.
// A redirect from the compare-and-branch unit retargets the PC. A read that is already
// in flight is allowed to complete but its data is discarded (the SQUASH state).
module pc_fetch
  import hap_pkg::*;
#(
  parameter int                ADDR_W   = HAP_ADDR_W,
  parameter int                INSTR_W  = HAP_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               if_ready
);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] tgt_next;
  logic              capture;

  // The memory is always addressed by the PC register, so the address is stable while a request is open
  assign imem_addr = pc;

  // Next-state and PC selection; redirect outranks ack, which outranks if_ready
  always_comb begin
    state_next = state;
    pc_next    = pc;
    tgt_next   = tgt;
    capture    = 1'b0;
    case (state)
      FS_IDLE: begin
        // Any ack arriving here belongs to a request from before reset and is ignored
        if (redirect_valid) begin
          pc_next = redirect_addr;
        end
        state_next = FS_WAIT;
      end
      FS_WAIT: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            // The word just returned is wrong-path, so re-fetch at the target straight away
            pc_next    = redirect_addr;
            state_next = FS_WAIT;
          end else begin
            capture    = 1'b1;
            state_next = FS_HOLD;
          end
        end else if (redirect_valid) begin
          // Keep the old request up until it completes; remember where to go afterwards
          tgt_next   = redirect_addr;
          state_next = FS_SQUASH;
        end
      end
      FS_SQUASH: begin
        if (redirect_valid) begin
          tgt_next = redirect_addr;
        end
        if (imem_ack) begin
          pc_next    = redirect_valid ? redirect_addr : tgt;
          state_next = FS_WAIT;
        end
      end
      FS_HOLD: begin
        if (redirect_valid) begin
          pc_next    = redirect_addr;
          state_next = FS_WAIT;
        end else if (if_ready) begin
          // Sequential fetch; wraps from the top of the address space back to zero
          pc_next    = pc + ADDR_W'(1);
          state_next = FS_WAIT;
        end
      end
      default: begin
        state_next = FS_IDLE;
      end
    endcase
  end

  // State, PC, pending target and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FS_IDLE;
      pc       <= RESET_PC;
      tgt      <= '0;
      imem_req <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      tgt      <= tgt_next;
      imem_req <= fetch_busy(state_next);
      if_valid <= (state_next == FS_HOLD);
      if (capture) begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch.
// A small memory model acks each request after a programmable number of cycles.
// It returns the word {~addr, addr}.
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
  logic        if_ready;

  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        stray_ack;
  int          mem_lat;
  int          mem_age;

  int n_pass;
  int n_total;

  pc_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign imem_ack   = mem_ack | stray_ack;
  assign imem_rdata = stray_ack ? 16'hDEAD : mem_rdata;

  // Memory model: ack once the request has been seen for mem_lat cycles
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mem_ack = 1'b0;
      mem_age = 0;
    end else if (imem_req && mem_age >= mem_lat) begin
      mem_ack   = 1'b1;
      mem_rdata = {~imem_addr, imem_addr};
      mem_age   = 0;
    end else begin
      mem_ack = 1'b0;
      mem_age = imem_req ? mem_age + 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    mem_ack        = 1'b0;
    mem_rdata      = '0;
    mem_age        = 0;
    mem_lat        = 0;
    stray_ack      = 1'b0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 8'h00;
    if_ready       = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_req",   imem_req, 0);
    chk("rst_addr",  imem_addr, 32'h00);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 32'h0000);
    chk("rst_pc",    if_pc, 32'h00);
    rst_n    = 1'b1;
    if_ready = 1'b1;

    // 1: sequential fetch with a same-cycle memory, decode always ready
    tick();
    chk("t1_req0",   imem_req, 1);
    chk("t1_addr0",  imem_addr, 32'h00);
    chk("t1_nval0",  if_valid, 0);
    tick();
    chk("t1_val0",   if_valid, 1);
    chk("t1_pc0",    if_pc, 32'h00);
    chk("t1_ins0",   if_instr, 32'hFF00);
    chk("t1_reqlo",  imem_req, 0);
    tick();
    chk("t1_nval1",  if_valid, 0);
    chk("t1_addr1",  imem_addr, 32'h01);
    tick();
    chk("t1_val1",   if_valid, 1);
    chk("t1_pc1",    if_pc, 32'h01);
    chk("t1_ins1",   if_instr, 32'hFE01);
    tick();
    chk("t1_addr2",  imem_addr, 32'h02);
    tick();
    chk("t1_pc2",    if_pc, 32'h02);
    chk("t1_ins2",   if_instr, 32'hFD02);

    // 2: decode stalls for five cycles
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_valid", if_valid, 1);
      chk("t2_pc",    if_pc, 32'h02);
      chk("t2_instr", if_instr, 32'hFD02);
      chk("t2_req",   imem_req, 0);
      chk("t2_addr",  imem_addr, 32'h02);
    end
    if_ready = 1'b1;

    // 3: redirect in HOLD at pc 05 beats if_ready
    repeat (6) tick();
    chk("t3_val05",  if_valid, 1);
    chk("t3_pc05",   if_pc, 32'h05);
    redirect_valid = 1'b1;
    redirect_addr  = 8'h40;
    tick();
    redirect_valid = 1'b0;
    chk("t3_addr40", imem_addr, 32'h40);
    chk("t3_req",    imem_req, 1);
    chk("t3_nval",   if_valid, 0);
    tick();
    chk("t3_pc40",   if_pc, 32'h40);
    chk("t3_ins40",  if_instr, 32'hBF40);

    // 4: redirect while waiting on a 3-cycle memory
    mem_lat = 3;
    tick();
    chk("t4_addr41", imem_addr, 32'h41);
    redirect_valid = 1'b1;
    redirect_addr  = 8'h20;
    tick();
    redirect_valid = 1'b0;
    chk("t4_sq_req",  imem_req, 1);
    chk("t4_sq_addr", imem_addr, 32'h41);
    chk("t4_sq_nval", if_valid, 0);
    tick();
    chk("t4_sq_addr2", imem_addr, 32'h41);
    tick();
    tick();
    chk("t4_addr20",  imem_addr, 32'h20);
    chk("t4_req20",   imem_req, 1);
    chk("t4_nval",    if_valid, 0);
    repeat (4) tick();
    chk("t4_val",     if_valid, 1);
    chk("t4_pc20",    if_pc, 32'h20);
    chk("t4_ins20",   if_instr, 32'hDF20);

    // 5: two redirects during one SQUASH, then a redirect coincident with ack
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = 8'h10;
    tick();
    redirect_addr  = 8'h30;
    tick();
    redirect_valid = 1'b0;
    chk("t5_sq_addr", imem_addr, 32'h21);
    tick();
    tick();
    chk("t5_addr30",  imem_addr, 32'h30);
    chk("t5_req30",   imem_req, 1);
    chk("t5_nval",    if_valid, 0);
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = 8'h50;
    tick();
    redirect_valid = 1'b0;
    chk("t5_addr50",  imem_addr, 32'h50);
    chk("t5_req50",   imem_req, 1);
    chk("t5_drop",    if_valid, 0);
    repeat (4) tick();
    chk("t5_val",     if_valid, 1);
    chk("t5_pc50",    if_pc, 32'h50);
    chk("t5_ins50",   if_instr, 32'hAF50);

    // 6: PC wrap from FF to 00
    mem_lat        = 0;
    redirect_valid = 1'b1;
    redirect_addr  = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    chk("t6_addrFF",  imem_addr, 32'hFF);
    tick();
    chk("t6_valFF",   if_valid, 1);
    chk("t6_pcFF",    if_pc, 32'hFF);
    chk("t6_insFF",   if_instr, 32'h00FF);
    tick();
    chk("t6_wrap",    imem_addr, 32'h00);
    chk("t6_wrapreq", imem_req, 1);

    // 6: asynchronous reset while a request is open, then a stray ack in IDLE
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_ar_req",   imem_req, 0);
    chk("t6_ar_addr",  imem_addr, 32'h00);
    chk("t6_ar_valid", if_valid, 0);
    chk("t6_ar_instr", if_instr, 32'h0000);
    chk("t6_ar_pc",    if_pc, 32'h00);
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    chk("t6_st_req",   imem_req, 1);
    chk("t6_st_addr",  imem_addr, 32'h00);
    chk("t6_st_nval",  if_valid, 0);
    tick();
    chk("t6_st_val",   if_valid, 1);
    chk("t6_st_instr", if_instr, 32'hFF00);
    chk("t6_st_pc",    if_pc, 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
